// File: rtl/alu_multicycle.sv
// Execute-stage ALU with a valid/ready handshake. MUL, DIV and MOD share one
// iterative datapath; every other opcode completes in a single cycle.
module alu_multicycle #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [3:0]       alu_op,
    input  logic [1:0]       shift_type,
    input  logic [SHW-1:0]   shift_amt,
    input  logic             alu_invert_operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero_flag,
    output logic             negative_flag,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             busy
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3,
        OP_MOD = 4'h4, OP_AND = 4'h5, OP_ORR = 4'h6, OP_XOR = 4'h7,
        OP_BIC = 4'h8, OP_MVN = 4'h9, OP_CMP = 4'hA, OP_TST = 4'hB,
        OP_MVI = 4'hC
    } alu_op_e;

    typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shift_e;

    // The "result held" condition is IDLE with out_valid high.
    typedef enum logic [1:0] {IDLE, MUL_IT, DIV_IT, DIV_FIX} state_e;

    state_e           state, state_next;
    alu_op_e          op;
    logic [CW-1:0]    cnt;
    logic             cnt_last;
    logic [WIDTH-1:0] op_a, op_b, acc;
    logic             is_mod, neg_q, neg_r, div_ovf;
    logic             accept, start_mul, start_div;
    logic [WIDTH-1:0] b_inv, b_sh;
    int unsigned      rot_amt;
    logic [WIDTH:0]   sum_add, sum_sub;
    logic [WIDTH-1:0] res_int, res_out;
    logic             n_c, z_c, c_c, v_c, no_flags;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] mul_acc_next;
    logic [WIDTH:0]   div_shifted, div_diff;
    logic [WIDTH-1:0] q_signed, r_signed, fix_result;

    assign op        = alu_op_e'(alu_op);
    assign in_ready  = (state == IDLE) && (!out_valid || out_ready) && !flush && !rst;
    assign accept    = in_valid && in_ready;
    assign busy      = (state != IDLE);
    assign start_mul = accept && (op == OP_MUL);
    assign start_div = accept && (op == OP_DIV || op == OP_MOD) && (b_sh != '0);
    assign cnt_last  = (cnt == CW'(WIDTH - 1));

    // Operand 2 path: optional inversion, then the barrel shifter.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        b_sh    = '0;
        b_inv   = alu_invert_operand2 ? ~operand2 : operand2;
        rot_amt = 32'(shift_amt) % WIDTH;
        case (shift_e'(shift_type))
            SH_LSL:  b_sh = b_inv << shift_amt;
            SH_LSR:  b_sh = b_inv >> shift_amt;
            SH_ASR:  b_sh = $signed(b_inv) >>> shift_amt;
            default: b_sh = (b_inv >> rot_amt) | (b_inv << ((WIDTH - rot_amt) % WIDTH));
        endcase
    end

    always_comb begin
        sum_add  = {1'b0, operand1} + {1'b0, b_sh};
        sum_sub  = {1'b0, operand1} + {1'b0, ~b_sh} + {{WIDTH{1'b0}}, 1'b1};
        res_int  = '0;
        c_c      = 1'b0;
        v_c      = 1'b0;
        no_flags = 1'b0;
        case (op)
            OP_ADD: begin
                res_int = sum_add[WIDTH-1:0];
                c_c     = sum_add[WIDTH];
                v_c     = (operand1[WIDTH-1] == b_sh[WIDTH-1]) && (res_int[WIDTH-1] != operand1[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                res_int = sum_sub[WIDTH-1:0];
                c_c     = sum_sub[WIDTH];
                v_c     = (operand1[WIDTH-1] != b_sh[WIDTH-1]) && (res_int[WIDTH-1] != operand1[WIDTH-1]);
            end
            OP_AND, OP_TST: res_int = operand1 & b_sh;
            OP_ORR:         res_int = operand1 | b_sh;
            OP_XOR:         res_int = operand1 ^ b_sh;
            OP_BIC:         res_int = operand1 & ~b_sh;
            OP_MVN:         res_int = ~b_sh;
            OP_MVI:         res_int = b_sh;
            // DIV/MOD only finish here when the divisor is zero.
            OP_DIV, OP_MOD: begin
                res_int  = '1;
                no_flags = 1'b1;
            end
            default:        no_flags = 1'b1;
        endcase
        n_c     = no_flags ? 1'b0 : res_int[WIDTH-1];
        z_c     = no_flags ? 1'b0 : (res_int == '0);
        res_out = (op == OP_CMP || op == OP_TST) ? '0 : res_int;
    end

    assign a_mag        = operand1[WIDTH-1] ? -operand1 : operand1;
    assign b_mag        = b_sh[WIDTH-1] ? -b_sh : b_sh;
    assign mul_acc_next = op_b[0] ? acc + op_a : acc;
    assign div_shifted  = {acc, op_a[WIDTH-1]};
    assign div_diff     = div_shifted - {1'b0, op_b};
    assign q_signed     = neg_q ? -op_a : op_a;
    assign r_signed     = neg_r ? -acc : acc;
    assign fix_result   = is_mod ? r_signed : q_signed;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_mul)      state_next = MUL_IT;
                else if (start_div) state_next = DIV_IT;
            end
            MUL_IT:  if (cnt_last) state_next = IDLE;
            DIV_IT:  if (cnt_last) state_next = DIV_FIX;
            DIV_FIX: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            alu_result    <= '0;
            negative_flag <= 1'b0;
            zero_flag     <= 1'b0;
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
            cnt           <= '0;
            op_a          <= '0;
            op_b          <= '0;
            acc           <= '0;
            is_mod        <= 1'b0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            div_ovf       <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (out_ready) out_valid <= 1'b0;
                    if (start_mul) begin
                        op_a <= operand1;
                        op_b <= b_sh;
                        acc  <= '0;
                        cnt  <= '0;
                    end else if (start_div) begin
                        op_a    <= a_mag;
                        op_b    <= b_mag;
                        acc     <= '0;
                        cnt     <= '0;
                        is_mod  <= (op == OP_MOD);
                        neg_q   <= operand1[WIDTH-1] ^ b_sh[WIDTH-1];
                        neg_r   <= operand1[WIDTH-1];
                        div_ovf <= (operand1 == {1'b1, {(WIDTH-1){1'b0}}}) && (b_sh == '1);
                    end else if (accept) begin
                        out_valid     <= 1'b1;
                        alu_result    <= res_out;
                        negative_flag <= n_c;
                        zero_flag     <= z_c;
                        carry_flag    <= c_c;
                        overflow_flag <= v_c;
                    end
                end
                MUL_IT: begin
                    acc  <= mul_acc_next;
                    op_a <= op_a << 1;
                    op_b <= op_b >> 1;
                    cnt  <= cnt + CW'(1);
                    if (cnt_last) begin
                        out_valid     <= 1'b1;
                        alu_result    <= mul_acc_next;
                        negative_flag <= mul_acc_next[WIDTH-1];
                        zero_flag     <= (mul_acc_next == '0);
                        carry_flag    <= 1'b0;
                        overflow_flag <= 1'b0;
                    end
                end
                DIV_IT: begin
                    // Restoring step: quotient bits shift into op_a, remainder lives in acc.
                    op_a <= {op_a[WIDTH-2:0], ~div_diff[WIDTH]};
                    acc  <= div_diff[WIDTH] ? div_shifted[WIDTH-1:0] : div_diff[WIDTH-1:0];
                    cnt  <= cnt + CW'(1);
                end
                DIV_FIX: begin
                    out_valid     <= 1'b1;
                    alu_result    <= fix_result;
                    negative_flag <= fix_result[WIDTH-1];
                    zero_flag     <= (fix_result == '0);
                    carry_flag    <= 1'b0;
                    overflow_flag <= div_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule
